// File: rtl/mod_mult_stream.sv
// mod_mult_stream: pipelined (a*b) mod MODULUS with a tiled multiplier, Barrett reduction and valid/ready flow; MOD_MULT_STREAM_OBUF_EN selects a credit-fed output FIFO
module mod_mult_stream #(
  parameter int BITS = 64,
  parameter logic [BITS:0] MODULUS = 65'hFFFF_FFFF_FFFF_FFC5,
  parameter int A_DSP_W = 17,
  parameter int B_DSP_W = 26,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_val,
  output logic             o_rdy,
  input  logic [BITS-1:0]  i_dat_a,
  input  logic [BITS-1:0]  i_dat_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_val,
  input  logic             i_rdy,
  output logic [BITS-1:0]  o_dat,
  output logic [TAG_W-1:0] o_tag
);
  localparam int NA = (BITS + A_DSP_W - 1) / A_DSP_W;
  localparam int NB = (BITS + B_DSP_W - 1) / B_DSP_W;
  localparam int PW = A_DSP_W + B_DSP_W;
  localparam int XW = 2 * BITS;
  localparam int RW = BITS + 2;
  localparam int EW = XW + BITS + 2;
  localparam logic [BITS-1:0] M = MODULUS[BITS-1:0];
  localparam logic [XW:0] MU = {1'b1, {XW{1'b0}}} / (XW+1)'(MODULUS);
  if (MODULUS <= (BITS+1)'(1) || MODULUS[BITS]) begin : g_bad_modulus
    $error("MODULUS must satisfy 1 < MODULUS < 2**BITS");
  end
  logic adv, acc;
  logic v1, v2, v3;
  logic [BITS-1:0] a1, b1;
  logic [TAG_W-1:0] t1, t2, t3;
  logic [PW-1:0] pp [NA][NB];
  logic [NA*A_DSP_W-1:0] ap;
  logic [NB*B_DSP_W-1:0] bp;
  logic [XW-1:0] x_c;
  logic [RW-1:0] x3, q3, r0, r1;
  logic [RW:0] d1, d2;
  logic [BITS-1:0] res;
  // x and q are exact, and r = x - q*M < 3*M fits RW bits, so only their low RW bits are kept
  always_comb begin
    ap = (NA*A_DSP_W)'(a1);
    bp = (NB*B_DSP_W)'(b1);
    x_c = '0;
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NB; j++)
        x_c = x_c + (XW'(pp[i][j]) << (i * A_DSP_W + j * B_DSP_W));
    r0 = x3 - q3 * RW'(M);
    d1 = {1'b0, r0} - (RW+1)'(M);
    r1 = d1[RW] ? r0 : d1[RW-1:0];
    d2 = {1'b0, r1} - (RW+1)'(M);
    res = BITS'(d2[RW] ? r1 : d2[RW-1:0]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= acc;
      v2 <= v1;
      v3 <= v2;
      a1 <= i_dat_a;
      b1 <= i_dat_b;
      t1 <= i_tag;
      t2 <= t1;
      t3 <= t2;
      for (int i = 0; i < NA; i++)
        for (int j = 0; j < NB; j++)
          pp[i][j] <= PW'(ap[i*A_DSP_W +: A_DSP_W]) * PW'(bp[j*B_DSP_W +: B_DSP_W]);
      x3 <= RW'(x_c);
      q3 <= RW'((EW'(x_c >> (BITS - 1)) * EW'(MU)) >> (BITS + 1));
    end
  end
`ifdef MOD_MULT_STREAM_OBUF_EN
  localparam int DEPTH = 6;
  logic v4, pop;
  logic [BITS-1:0] r4;
  logic [TAG_W-1:0] t4;
  logic [BITS-1:0] fd [DEPTH];
  logic [TAG_W-1:0] ft [DEPTH];
  logic [2:0] cnt, cnt_n, wi;
  assign adv = 1'b1;
  assign acc = i_val & o_rdy;
  assign pop = o_val & i_rdy;
  assign cnt_n = cnt + 3'(v4) - 3'(pop);
  assign wi = cnt - 3'(pop);
  assign o_val = cnt != 3'd0;
  assign o_dat = fd[0];
  assign o_tag = ft[0];
  // credits cover every beat in the pipe, so the FIFO can always absorb what S4 delivers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v4 <= 1'b0;
      cnt <= 3'd0;
      o_rdy <= 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        fd[k] <= '0;
        ft[k] <= '0;
      end
    end else begin
      v4 <= v3;
      r4 <= res;
      t4 <= t3;
      cnt <= cnt_n;
      o_rdy <= (4'(cnt_n) + 4'(acc) + 4'(v1) + 4'(v2) + 4'(v3)) < 4'(DEPTH);
      if (pop)
        for (int k = 0; k < DEPTH - 1; k++) begin
          fd[k] <= fd[k+1];
          ft[k] <= ft[k+1];
        end
      if (v4) begin
        fd[wi] <= r4;
        ft[wi] <= t4;
      end
    end
  end
`else
  assign adv = ~o_val | i_rdy;
  assign o_rdy = adv;
  assign acc = i_val & o_rdy;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_val <= 1'b0;
      o_dat <= '0;
      o_tag <= '0;
    end else if (adv) begin
      o_val <= v3;
      o_dat <= res;
      o_tag <= t3;
    end
  end
`endif
endmodule

// File: tb/tb_mod_mult_stream.sv
// tb_mod_mult_stream: directed and randomized checks of mod_mult_stream against an arithmetic reference
`timescale 1ns/1ps
module tb_mod_mult_stream;
  localparam int BITS = 16;
  localparam int TAG_W = 4;
  localparam longint MODV = 65521;
`ifdef MOD_MULT_STREAM_OBUF_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  logic clk = 1'b0, rst = 1'b1, i_val = 1'b0, i_rdy = 1'b1, o_rdy, o_val;
  logic [BITS-1:0] a = '0, b = '0, o_dat;
  logic [TAG_W-1:0] tag = '0, o_tag;
  int checks = 0, passed = 0;

  mod_mult_stream #(.BITS(16), .MODULUS(17'd65521), .A_DSP_W(9), .B_DSP_W(8), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat_a(a), .i_dat_b(b),
    .i_tag(tag), .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t);
    longint p = longint'(x) * longint'(y);
    return {t, 16'(p % MODV)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MOD_MULT_STREAM_OBUF_EN
  always @(negedge clk)
    if (!rst && dut.v4) begin
      checks++;
      if (dut.cnt == 3'd6) $display("FAIL fifo_overflow: S4 result arrived with count %0d, required < 6", dut.cnt);
      else passed++;
    end
`endif

  task automatic test_reset();
    rst = 1'b1; i_val = 1'b0; i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_val !== 1'b0) $display("FAIL reset_o_val got %0b want 0", o_val); else passed++;
    checks++; if (o_dat !== 16'd0) $display("FAIL reset_o_dat got %0d want 0", o_dat); else passed++;
    checks++; if (o_tag !== 4'd0) $display("FAIL reset_o_tag got %0d want 0", o_tag); else passed++;
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (o_rdy !== 1'b1) $display("FAIL reset_o_rdy got %0b want 1", o_rdy); else passed++;
    tick();
  endtask

  task automatic test_basic();
    logic took;
    int lat = -1;
    a = 16'd12345; b = 16'd54321; tag = 4'd3; i_val = 1'b1; i_rdy = 1'b1;
    @(negedge clk);
    took = o_rdy;
    tick();
    i_val = 1'b0;
    for (int k = 0; k <= LAT + 3 && lat < 0; k++) begin
      @(negedge clk);
      if (o_val) lat = k + 1;
      else tick();
    end
    checks++; if (took !== 1'b1) $display("FAIL basic_accept got o_rdy=%0b want 1", took); else passed++;
    checks++; if (lat != LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passed++;
    checks++; if (o_dat !== 16'd50831) $display("FAIL basic_dat got %0d want 50831", o_dat); else passed++;
    checks++; if (o_tag !== 4'd3) $display("FAIL basic_tag got %0d want 3", o_tag); else passed++;
    tick();
  endtask

  task automatic test_corners();
    logic [15:0] arr_a [4], arr_b [4], arr_e [4];
    int sent = 0, got = 0, cyc = 0;
    arr_a = '{16'd65520, 16'd65535, 16'd0, 16'd1};
    arr_b = '{16'd65520, 16'd2, 16'd65535, 16'd65520};
    arr_e = '{16'd1, 16'd28, 16'd0, 16'd65520};
    i_rdy = 1'b1;
    while (got < 4 && cyc < 40) begin
      i_val = sent < 4;
      if (sent < 4) begin a = arr_a[sent]; b = arr_b[sent]; tag = 4'(sent + 8); end
      @(negedge clk);
      if (o_val) begin
        checks++;
        if ({o_tag, o_dat} !== {4'(got + 8), arr_e[got]})
          $display("FAIL corner_%0d got tag=%0d dat=%0d want tag=%0d dat=%0d", got, o_tag, o_dat, got + 8, arr_e[got]);
        else passed++;
        got++;
      end
      if (i_val && o_rdy) sent++;
      tick();
      cyc++;
    end
    i_val = 1'b0;
    checks++; if (got != 4) $display("FAIL corner_count got %0d want 4", got); else passed++;
  endtask

  task automatic test_stream();
    logic [19:0] q [$];
    logic [19:0] exp_v;
    int sent = 0, got = 0, cyc = 0, gaps = 0;
    i_rdy = 1'b1;
    while (got < 1000 && cyc < 1100) begin
      i_val = sent < 1000;
      a = 16'($urandom); b = 16'($urandom); tag = 4'($urandom);
      @(negedge clk);
      if (i_val && o_rdy) begin q.push_back(model(a, b, tag)); sent++; end
      if (o_val) begin
        exp_v = 20'hxxxxx;
        if (q.size() != 0) exp_v = q.pop_front();
        checks++;
        if ({o_tag, o_dat} !== exp_v)
          $display("FAIL stream_%0d got tag=%0d dat=%0d want tag=%0d dat=%0d", got, o_tag, o_dat, exp_v[19:16], exp_v[15:0]);
        else passed++;
        checks++; if (o_dat >= 16'd65521) $display("FAIL stream_range got %0d want < 65521", o_dat); else passed++;
        got++;
      end else if (got > 0) gaps++;
      tick();
      cyc++;
    end
    i_val = 1'b0;
    checks++; if (got != 1000) $display("FAIL stream_count got %0d want 1000", got); else passed++;
    checks++; if (gaps != 0) $display("FAIL stream_gaps got %0d want 0", gaps); else passed++;
    checks++; if (cyc != 1000 + LAT) $display("FAIL stream_cycles got %0d want %0d", cyc, 1000 + LAT); else passed++;
  endtask

  task automatic test_backpressure();
    logic [19:0] q [$];
    logic [19:0] held, exp_v;
    logic stalled = 1'b0, took;
    int sent = 0, got = 0, cyc = 0, oc = 0, extra = 0;
    i_val = 1'b0;
    while (got < 8 && cyc < 60) begin
      i_rdy = !(oc >= 2 && oc <= 5);
      if (!i_val && sent < 8) begin
        i_val = 1'b1; a = 16'($urandom); b = 16'($urandom); tag = 4'(sent);
      end
      @(negedge clk);
      if (o_val || oc > 0) oc++;
`ifndef MOD_MULT_STREAM_OBUF_EN
      if (o_val) begin
        checks++; if (o_rdy !== i_rdy) $display("FAIL bp_o_rdy got %0b want %0b", o_rdy, i_rdy); else passed++;
      end
`endif
      if (stalled) begin
        checks++;
        if (!o_val || {o_tag, o_dat} !== held)
          $display("FAIL bp_hold got val=%0b tag=%0d dat=%0d want val=1 tag=%0d dat=%0d", o_val, o_tag, o_dat, held[19:16], held[15:0]);
        else passed++;
      end
      stalled = o_val && !i_rdy;
      held = {o_tag, o_dat};
      took = i_val && o_rdy;
      if (took) begin q.push_back(model(a, b, tag)); sent++; end
      if (o_val && i_rdy) begin
        exp_v = 20'hxxxxx;
        if (q.size() != 0) exp_v = q.pop_front();
        checks++;
        if ({o_tag, o_dat} !== exp_v)
          $display("FAIL bp_%0d got tag=%0d dat=%0d want tag=%0d dat=%0d", got, o_tag, o_dat, exp_v[19:16], exp_v[15:0]);
        else passed++;
        got++;
      end
      tick();
      cyc++;
      if (took) i_val = 1'b0;
    end
    i_val = 1'b0; i_rdy = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (o_val) extra++;
      tick();
    end
    checks++; if (got != 8) $display("FAIL bp_count got %0d want 8", got); else passed++;
    checks++; if (extra != 0) $display("FAIL bp_duplicate got %0d extra results want 0", extra); else passed++;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    i_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_val = 1'b1; a = 16'($urandom_range(1000, 65535)); b = 16'($urandom_range(1000, 65535)); tag = 4'(k + 5);
      tick();
    end
    i_val = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_val !== 1'b0) $display("FAIL rst_mid_o_val got %0b want 0", o_val); else passed++;
    checks++; if (o_dat !== 16'd0) $display("FAIL rst_mid_o_dat got %0d want 0", o_dat); else passed++;
    checks++; if (o_tag !== 4'd0) $display("FAIL rst_mid_o_tag got %0d want 0", o_tag); else passed++;
    tick();
    repeat (LAT + 3) begin
      @(negedge clk);
      if (o_val) stale++;
      tick();
    end
    checks++; if (stale != 0) $display("FAIL rst_mid_stale got %0d results want 0", stale); else passed++;
  endtask

`ifdef MOD_MULT_STREAM_OBUF_EN
  task automatic test_credit();
    logic [19:0] q [$];
    logic [19:0] exp_v;
    int acc_n = 0, got = 0, cyc = 0;
    i_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_val = 1'b1; a = 16'($urandom); b = 16'($urandom); tag = 4'(k);
      @(negedge clk);
      if (o_rdy) begin q.push_back(model(a, b, tag)); acc_n++; end
      tick();
    end
    i_val = 1'b0;
    @(negedge clk);
    checks++; if (acc_n != 6) $display("FAIL credit_accepts got %0d want 6", acc_n); else passed++;
    checks++; if (o_rdy !== 1'b0) $display("FAIL credit_full_o_rdy got %0b want 0", o_rdy); else passed++;
    tick();
    i_rdy = 1'b1;
    while (got < 6 && cyc < 30) begin
      @(negedge clk);
      if (got == 0) begin
        checks++; if (o_rdy !== 1'b0) $display("FAIL credit_pre_pop_o_rdy got %0b want 0", o_rdy); else passed++;
      end
      if (got == 1) begin
        checks++; if (o_rdy !== 1'b1) $display("FAIL credit_return_o_rdy got %0b want 1", o_rdy); else passed++;
      end
      if (o_val) begin
        exp_v = 20'hxxxxx;
        if (q.size() != 0) exp_v = q.pop_front();
        checks++;
        if ({o_tag, o_dat} !== exp_v)
          $display("FAIL credit_%0d got tag=%0d dat=%0d want tag=%0d dat=%0d", got, o_tag, o_dat, exp_v[19:16], exp_v[15:0]);
        else passed++;
        got++;
      end
      tick();
      cyc++;
    end
    checks++; if (got != 6) $display("FAIL credit_drain got %0d want 6", got); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef MOD_MULT_STREAM_OBUF_EN
    test_credit();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
